mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter_pkg.sv | 26 ++
 rtl/mem_arbiter_picker.sv | 39 +++
 rtl/mem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
// Shared types and constants for the data-memory arbiter.
//   arb_state_t     : arbiter FSM states (IDLE, BUSY, DONE)
//   arb_port_t      : requester index (PORT_CPU = 0, PORT_DMA = 1)
//   MEM_LATENCY_MAX : largest supported memory latency
//   otherPort()     : returns the requester that is not the argument
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } arb_port_t;

  localparam int MEM_LATENCY_MAX = 4;

  function automatic arb_port_t otherPort(input arb_port_t p);
    return (p == PORT_CPU) ? PORT_DMA : PORT_CPU;
  endfunction

endpackage

// File: rtl/mem_arbiter_picker.sv
// arb_picker
// Combinational winner selection between the CPU and DMA requesters.
// Build option: MEM_ARBITER_RR_EN
//   defined   : ties go to the port that was not granted last (round-robin)
//   undefined : ties always go to the CPU (fixed priority), no last-grant input
// Ports:
//   lastGnt_i : port granted most recently (round-robin build only)
//   reqCpu_i  : CPU request
//   reqDma_i  : DMA request
//   valid_o   : at least one request is pending
//   gnt_o     : winning port, meaningful only when valid_o is high
module arb_picker
  import mem_arbiter_pkg::*;
(
`ifdef MEM_ARBITER_RR_EN
  input  arb_port_t lastGnt_i,
`endif
  input  logic      reqCpu_i,
  input  logic      reqDma_i,
  output logic      valid_o,
  output arb_port_t gnt_o
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    valid_o = reqCpu_i | reqDma_i;
    gnt_o   = PORT_CPU;
    if (reqCpu_i && reqDma_i) begin
`ifdef MEM_ARBITER_RR_EN
      gnt_o = otherPort(lastGnt_i);
`else
      gnt_o = PORT_CPU;
`endif
    end else if (reqDma_i) begin
      gnt_o = PORT_DMA;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single data-memory port between the CPU load/store path
// (port 0) and a DMA/debug master (port 1). One transaction at a time:
// grant in IDLE, drive the memory for MEM_LATENCY cycles in BUSY from
// latched copies, then pulse the winner's ack in DONE.
// Build option: MEM_ARBITER_RR_EN selects round-robin on ties (see arb_picker);
// without it the CPU wins every tie and no last-grant register exists.
// Parameters: DATA_WIDTH, ADDR_WIDTH, MEM_LATENCY (1..MEM_LATENCY_MAX)
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_cpu_req/we/addr/wdata      : port 0 request, held until o_cpu_ack
//   o_cpu_rdata, o_cpu_ack       : port 0 read data and completion pulse
//   i_dma_* / o_dma_*            : same for port 1
//   o_mem_en/we/addr/wdata       : registered memory-side controls
//   i_mem_rdata                  : memory read data
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 12,
  parameter int MEM_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_ack,
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic                  o_dma_ack,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

  // Out-of-range latencies are pulled into the supported window.
  localparam int LAT = (MEM_LATENCY < 1) ? 1 :
                       (MEM_LATENCY > MEM_LATENCY_MAX) ? MEM_LATENCY_MAX : MEM_LATENCY;
  localparam int CNT_W = $clog2(LAT) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  arb_state_t            state_q;
  arb_port_t             gnt_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cnt_d;
  logic                  we_q;
  logic                  memEn_q;
  logic                  memWe_q;
  logic [ADDR_WIDTH-1:0] memAddr_q;
  logic [DATA_WIDTH-1:0] memWdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  cpuAck_q;
  logic                  dmaAck_q;

  logic                  pickValid;
  arb_port_t             pickGnt;
  logic                  gntWe_d;
  logic [ADDR_WIDTH-1:0] gntAddr_d;
  logic [DATA_WIDTH-1:0] gntWdata_d;

`ifdef MEM_ARBITER_RR_EN
  arb_port_t             lastGnt_q;
`endif

  arb_picker u_picker (
`ifdef MEM_ARBITER_RR_EN
    .lastGnt_i (lastGnt_q),
`endif
    .reqCpu_i  (i_cpu_req),
    .reqDma_i  (i_dma_req),
    .valid_o   (pickValid),
    .gnt_o     (pickGnt)
  );

  // Request fields of whichever port the picker chose this cycle.
  assign gntWe_d    = (pickGnt == PORT_DMA) ? i_dma_we    : i_cpu_we;
  assign gntAddr_d  = (pickGnt == PORT_DMA) ? i_dma_addr  : i_cpu_addr;
  assign gntWdata_d = (pickGnt == PORT_DMA) ? i_dma_wdata : i_cpu_wdata;
  assign cnt_d      = cnt_q - 1'b1;

  // Arbiter FSM. Memory controls are loaded on the grant edge so the first
  // BUSY cycle already presents the latched request; nothing combinational
  // reaches the memory from the requesters. The write strobe is cleared
  // after the first BUSY cycle, giving exactly one strobe per transaction.
  // The counter only decrements while non-zero, so it never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      gnt_q      <= PORT_CPU;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      memEn_q    <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      rdata_q    <= '0;
      cpuAck_q   <= 1'b0;
      dmaAck_q   <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      lastGnt_q  <= PORT_DMA;
`endif
    end else begin
      cpuAck_q <= 1'b0;
      dmaAck_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pickValid) begin
            gnt_q      <= pickGnt;
            we_q       <= gntWe_d;
            memEn_q    <= 1'b1;
            memWe_q    <= gntWe_d;
            memAddr_q  <= gntAddr_d;
            memWdata_q <= gntWdata_d;
            cnt_q      <= CNT_LOAD;
            state_q    <= BUSY;
`ifdef MEM_ARBITER_RR_EN
            lastGnt_q  <= pickGnt;
`endif
          end
        end
        BUSY: begin
          memWe_q <= 1'b0;
          if (cnt_q == '0) begin
            if (!we_q) begin
              rdata_q <= i_mem_rdata;
            end
            memEn_q  <= 1'b0;
            cpuAck_q <= (gnt_q == PORT_CPU);
            dmaAck_q <= (gnt_q == PORT_DMA);
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign o_mem_en    = memEn_q;
  assign o_mem_we    = memWe_q;
  assign o_mem_addr  = memAddr_q;
  assign o_mem_wdata = memWdata_q;
  assign o_cpu_ack   = cpuAck_q;
  assign o_dma_ack   = dmaAck_q;
  assign o_cpu_rdata = rdata_q;
  assign o_dma_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Randomized bench for mem_arbiter with a transaction-level reference model.
// Requesters are modelled as queues of pending transactions per port; the
// model decides grants from the tie rule and derives expected memory and ack
// timing from the grant cycle with plain arithmetic. Honours MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

  localparam int DW        = 16;
  localparam int AW        = 12;
  localparam int LAT       = 3;
  localparam int ADDR_SPAN = 16;
  localparam int NCYC      = 3000;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_cpu_req, i_cpu_we, i_dma_req, i_dma_we;
  logic [AW-1:0] i_cpu_addr, i_dma_addr;
  logic [DW-1:0] i_cpu_wdata, i_dma_wdata;
  logic [DW-1:0] o_cpu_rdata, o_dma_rdata;
  logic          o_cpu_ack, o_dma_ack;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [DW-1:0] i_mem_rdata;

  logic [DW-1:0] memArr [0:(1<<AW)-1];
  logic [DW-1:0] refMem [0:(1<<AW)-1];

  mem_arbiter #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .MEM_LATENCY (LAT)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_cpu_req   (i_cpu_req),
    .i_cpu_we    (i_cpu_we),
    .i_cpu_addr  (i_cpu_addr),
    .i_cpu_wdata (i_cpu_wdata),
    .o_cpu_rdata (o_cpu_rdata),
    .o_cpu_ack   (o_cpu_ack),
    .i_dma_req   (i_dma_req),
    .i_dma_we    (i_dma_we),
    .i_dma_addr  (i_dma_addr),
    .i_dma_wdata (i_dma_wdata),
    .o_dma_rdata (o_dma_rdata),
    .o_dma_ack   (o_dma_ack),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_wdata (o_mem_wdata),
    .i_mem_rdata (i_mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 i_clk = ~i_clk;

  // Data RAM stand-in: read data follows the presented address, writes land
  // on the strobe edge.
  assign i_mem_rdata = memArr[o_mem_addr];

  always @(posedge i_clk) begin
    if (o_mem_we) begin
      memArr[o_mem_addr] <= o_mem_wdata;
    end
  end

  int compared   = 0;
  int mismatched = 0;

  // Requester shadows: what each port intends to present, and how many
  // transactions it still wants to complete.
  logic          curReq   [2];
  logic          curWe    [2];
  logic [AW-1:0] curAddr  [2];
  logic [DW-1:0] curWdata [2];
  int            txLeft   [2];

  // Reference model: the one transaction in flight and the arbiter's memory.
  bit            mActive;
  int            mStart;
  int            mPort;
  logic          mWe;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWdata;
  int            mLast;
  logic [DW-1:0] mRdata;
  int            mNextSample;
  bit            scramble;
  bit            rstArmed;
  bit            rstDone;
  int            rstCheckCycle;
  bit            allowNew;
  int            episode;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input int port, input logic req, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    if (port == 0) begin
      i_cpu_req = req; i_cpu_we = we; i_cpu_addr = addr; i_cpu_wdata = wdata;
    end else begin
      i_dma_req = req; i_dma_we = we; i_dma_addr = addr; i_dma_wdata = wdata;
    end
  endtask

  task automatic newRequest(input int port);
    curReq[port]   = 1'b1;
    curWe[port]    = 1'($urandom_range(0, 1));
    curAddr[port]  = AW'($urandom_range(0, ADDR_SPAN - 1));
    curWdata[port] = DW'($urandom);
    applyStimulus(port, 1'b1, curWe[port], curAddr[port], curWdata[port]);
  endtask

  task automatic dropRequest(input int port);
    curReq[port] = 1'b0;
    applyStimulus(port, 1'b0, 1'b0, '0, '0);
  endtask

  // One model step, called mid-cycle k: check the DUT outputs expected for
  // cycle k, then update requesters and model for the inputs of cycle k.
  task automatic stepCycle(input int k);
    logic expEn, expWe, ackNow;
    int   w;

    if (k == rstCheckCycle) begin
      checkOutput("rst_mem_addr",  32'(o_mem_addr),  32'h0);
      checkOutput("rst_mem_wdata", 32'(o_mem_wdata), 32'h0);
      checkOutput("rst_rdata",     32'(o_cpu_rdata), 32'h0);
      i_rst = 1'b0;
    end

    expEn  = mActive && (k >= mStart + 1) && (k <= mStart + LAT);
    expWe  = expEn && mWe && (k == mStart + 1);
    ackNow = mActive && (k == mStart + LAT + 1);

    if (ackNow) begin
      if (mWe) refMem[mAddr] = mWdata;
      else     mRdata = refMem[mAddr];
    end

    checkOutput("mem_en",  32'(o_mem_en),  32'(expEn));
    checkOutput("mem_we",  32'(o_mem_we),  32'(expWe));
    checkOutput("cpu_ack", 32'(o_cpu_ack), 32'(ackNow && mPort == 0));
    checkOutput("dma_ack", 32'(o_dma_ack), 32'(ackNow && mPort == 1));
    if (expEn) begin
      checkOutput("mem_addr",  32'(o_mem_addr),  32'(mAddr));
      checkOutput("mem_wdata", 32'(o_mem_wdata), 32'(mWdata));
    end

    if (ackNow) begin
      if (mPort == 0) checkOutput("cpu_rdata", 32'(o_cpu_rdata), 32'(mRdata));
      else            checkOutput("dma_rdata", 32'(o_dma_rdata), 32'(mRdata));
      mActive     = 1'b0;
      mNextSample = k + 1;
      txLeft[mPort]--;
      if (txLeft[mPort] > 0) newRequest(mPort);
      else                   dropRequest(mPort);
    end

    // Reset in the second BUSY cycle of a read: the transaction is dropped.
    if (rstArmed && mActive && !mWe && (k == mStart + 2)) begin
      i_rst = 1'b1;
      dropRequest(0);
      dropRequest(1);
      txLeft[0]     = 0;
      txLeft[1]     = 0;
      mActive       = 1'b0;
      mLast         = 1;
      mRdata        = '0;
      mNextSample   = k + 1;
      rstCheckCycle = k + 1;
      rstArmed      = 1'b0;
      rstDone       = 1'b1;
    end

    // Requester misbehaves right after its grant; the transaction must not see it.
    if (mActive && scramble && (k == mStart + 1)) begin
      applyStimulus(mPort, 1'b1, 1'($urandom_range(0, 1)),
                    AW'($urandom_range(0, ADDR_SPAN - 1)), DW'($urandom));
    end

    if (allowNew && !i_rst && !mActive && txLeft[0] == 0 && txLeft[1] == 0 &&
        $urandom_range(0, 3) != 0) begin
      if (episode == 0) begin
        txLeft[0] = 4;
        txLeft[1] = 4;
      end else begin
        case ($urandom_range(0, 2))
          0:       begin txLeft[0] = $urandom_range(1, 3); txLeft[1] = 0; end
          1:       begin txLeft[0] = 0; txLeft[1] = $urandom_range(1, 3); end
          default: begin txLeft[0] = $urandom_range(1, 3); txLeft[1] = $urandom_range(1, 3); end
        endcase
      end
      for (int p = 0; p < 2; p++) begin
        if (txLeft[p] > 0) newRequest(p);
      end
      episode++;
    end

    if (!mActive && (k >= mNextSample) && (curReq[0] || curReq[1])) begin
      if (curReq[0] && curReq[1]) begin
`ifdef MEM_ARBITER_RR_EN
        w = (mLast == 1) ? 0 : 1;
`else
        w = 0;
`endif
      end else begin
        w = curReq[1] ? 1 : 0;
      end
      mLast    = w;
      mActive  = 1'b1;
      mStart   = k;
      mPort    = w;
      mWe      = curWe[w];
      mAddr    = curAddr[w];
      mWdata   = curWdata[w];
      scramble = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    int drainCount;

    for (int i = 0; i < (1 << AW); i++) begin
      logic [DW-1:0] v;
      v = DW'($urandom);
      memArr[i] = v;
      refMem[i] = v;
    end

    i_rst = 1'b1;
    for (int p = 0; p < 2; p++) begin
      dropRequest(p);
      txLeft[p] = 0;
    end
    mActive       = 1'b0;
    mStart        = 0;
    mPort         = 0;
    mWe           = 1'b0;
    mAddr         = '0;
    mWdata        = '0;
    mLast         = 1;
    mRdata        = '0;
    mNextSample   = 0;
    scramble      = 1'b0;
    rstArmed      = 1'b0;
    rstDone       = 1'b0;
    rstCheckCycle = -1;
    allowNew      = 1'b1;
    episode       = 0;

    repeat (3) @(negedge i_clk);
    checkOutput("reset_mem_en",    32'(o_mem_en),    32'h0);
    checkOutput("reset_mem_we",    32'(o_mem_we),    32'h0);
    checkOutput("reset_mem_addr",  32'(o_mem_addr),  32'h0);
    checkOutput("reset_mem_wdata", 32'(o_mem_wdata), 32'h0);
    checkOutput("reset_cpu_ack",   32'(o_cpu_ack),   32'h0);
    checkOutput("reset_dma_ack",   32'(o_dma_ack),   32'h0);
    checkOutput("reset_rdata",     32'(o_dma_rdata), 32'h0);
    i_rst = 1'b0;

    for (int k = 0; k < NCYC; k++) begin
      @(negedge i_clk);
      if (k == 600 && !rstDone) rstArmed = 1'b1;
      stepCycle(k);
    end

    allowNew   = 1'b0;
    rstArmed   = 1'b0;
    drainCount = 0;
    while ((mActive || txLeft[0] > 0 || txLeft[1] > 0) && drainCount < 200) begin
      @(negedge i_clk);
      stepCycle(NCYC + drainCount);
      drainCount++;
    end
    checkOutput("drain_timeout", 32'(mActive || txLeft[0] > 0 || txLeft[1] > 0), 32'h0);
    checkOutput("mid_reset_seen", 32'(rstDone), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
